// File: rtl/drs_event_parse.sv
// DRS event frame parser: byte FIFO -> 4-byte skid buffer -> 16-bit words with SOF/EOF/CH framing.
// Optional build macro DRS_PARSE_SAMPCHK_EN enables the [15:12]==0 sanity check on stop/sample words.
module drs_event_parse (
  input  logic        CLK,
  input  logic        RST,
  input  logic [12:0] READDEPTH,
  input  logic [7:0]  DFIFO_DOUT,
  input  logic        DFIFO_EMPTY,
  input  logic        DFIFO_VALID,
  output logic        DFIFO_RD_EN,
  output logic [15:0] EVT_DATA,
  output logic        EVT_VALID,
  input  logic        EVT_READY,
  output logic        EVT_SOF,
  output logic        EVT_EOF,
  output logic        EVT_CH,
  output logic [9:0]  STOPCELL,
  output logic [1:0]  STOPCH,
  output logic        FLAG_A,
  output logic        FLAG_B,
  output logic        HDR_STROBE,
  output logic        ERR_SYNC,
  output logic [15:0] EVT_COUNT,
  output logic        BUSY
);
  typedef enum logic [1:0] {HUNT = 2'd0, HDR = 2'd1, STOP = 2'd2, SAMP = 2'd3} state_e;

  state_e          state_q, state_d;
  logic [3:0][7:0] skid_q, skid_d, skid_shift;
  logic [2:0]      cnt_q, cnt_d, cnt_keep;
  logic            inflight_q, inflight_d;
  logic [12:0]     limit_q, limit_d;
  logic [13:0]     idx_q, idx_d, last_idx;
  logic [15:0]     evt_data_q, evt_data_d;
  logic            evt_valid_q, evt_valid_d, evt_sof_q, evt_sof_d;
  logic            evt_eof_q, evt_eof_d, evt_ch_q, evt_ch_d;
  logic [9:0]      stopcell_q, stopcell_d;
  logic [1:0]      stopch_q, stopch_d;
  logic            flag_a_q, flag_a_d, flag_b_q, flag_b_d;
  logic            hdr_strobe_q, hdr_strobe_d, err_sync_q, err_sync_d;
  logic [15:0]     evt_count_q, evt_count_d;
  logic [1:0]      pop;
  logic [15:0]     word;
  logic            word_avail, slot_free, is_hdr, word_bad, rd_en, take_hdr;

  // skid_q[0] is the oldest byte; words are formed high byte first
  assign word       = {skid_q[0], skid_q[1]};
  assign word_avail = cnt_q >= 3'd2;
  assign slot_free  = !evt_valid_q || EVT_READY;
  assign is_hdr     = (skid_q[0] == 8'hF0) && (skid_q[1][7:4] == 4'h0);
  assign last_idx   = {limit_q, 1'b0} - 14'd1;
`ifdef DRS_PARSE_SAMPCHK_EN
  assign word_bad   = word[15:12] != 4'h0;
`else
  assign word_bad   = 1'b0;
`endif
  // Reads in flight are reserved so an arriving byte always has a free slot
  assign rd_en = !RST && !DFIFO_EMPTY && (({1'b0, cnt_q} + {3'b000, inflight_q}) < 4'd4);

  always_comb begin
    state_d      = state_q;
    limit_d      = limit_q;
    idx_d        = idx_q;
    evt_data_d   = evt_data_q;
    evt_valid_d  = evt_valid_q;
    evt_sof_d    = evt_sof_q;
    evt_eof_d    = evt_eof_q;
    evt_ch_d     = evt_ch_q;
    stopcell_d   = stopcell_q;
    stopch_d     = stopch_q;
    flag_a_d     = flag_a_q;
    flag_b_d     = flag_b_q;
    evt_count_d  = evt_count_q;
    hdr_strobe_d = 1'b0;
    err_sync_d   = 1'b0;
    pop          = 2'd0;
    take_hdr     = 1'b0;
    inflight_d   = rd_en;
    if (evt_valid_q && EVT_READY) evt_valid_d = 1'b0;

    case (state_q)
      HUNT: if (word_avail) begin
        if (!is_hdr)        pop = 2'd1;
        else if (slot_free) take_hdr = 1'b1;
        else                state_d = HDR;
      end
      HDR: if (slot_free) take_hdr = 1'b1;
      STOP: if (word_avail && slot_free) begin
        pop         = 2'd2;
        evt_valid_d = 1'b1;
        evt_data_d  = word;
        evt_sof_d   = 1'b0;
        evt_ch_d    = 1'b0;
        evt_eof_d   = 1'b0;
        stopcell_d  = word[9:0];
        stopch_d    = word[11:10];
        if (word_bad) begin
          err_sync_d = 1'b1;
          evt_eof_d  = 1'b1;
          state_d    = HUNT;
        end else if (limit_q == 13'd0) begin
          evt_eof_d   = 1'b1;
          evt_count_d = evt_count_q + 16'd1;
          state_d     = HUNT;
        end else begin
          idx_d   = 14'd0;
          state_d = SAMP;
        end
      end
      SAMP: if (word_avail && slot_free) begin
        pop         = 2'd2;
        evt_valid_d = 1'b1;
        evt_data_d  = word;
        evt_sof_d   = 1'b0;
        evt_ch_d    = idx_q >= {1'b0, limit_q};
        evt_eof_d   = idx_q == last_idx;
        idx_d       = idx_q + 14'd1;
        if (word_bad) begin
          err_sync_d = 1'b1;
          evt_eof_d  = 1'b1;
          state_d    = HUNT;
        end else if (idx_q == last_idx) begin
          evt_count_d = evt_count_q + 16'd1;
          state_d     = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase

    if (take_hdr) begin
      pop          = 2'd2;
      evt_valid_d  = 1'b1;
      evt_data_d   = word;
      evt_sof_d    = 1'b1;
      evt_eof_d    = 1'b0;
      evt_ch_d     = 1'b0;
      flag_a_d     = word[0];
      flag_b_d     = word[1];
      limit_d      = READDEPTH;
      hdr_strobe_d = 1'b1;
      state_d      = STOP;
    end

    // Consume first, then append the arriving byte behind what remains
    skid_shift = skid_q >> {pop, 3'b000};
    cnt_keep   = cnt_q - {1'b0, pop};
    skid_d     = skid_shift;
    if (DFIFO_VALID) skid_d[cnt_keep[1:0]] = DFIFO_DOUT;
    cnt_d = cnt_keep + {2'b00, DFIFO_VALID};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= HUNT;
      skid_q       <= '0;
      cnt_q        <= 3'd0;
      inflight_q   <= 1'b0;
      limit_q      <= 13'd0;
      idx_q        <= 14'd0;
      evt_data_q   <= 16'd0;
      evt_valid_q  <= 1'b0;
      evt_sof_q    <= 1'b0;
      evt_eof_q    <= 1'b0;
      evt_ch_q     <= 1'b0;
      stopcell_q   <= 10'd0;
      stopch_q     <= 2'd0;
      flag_a_q     <= 1'b0;
      flag_b_q     <= 1'b0;
      hdr_strobe_q <= 1'b0;
      err_sync_q   <= 1'b0;
      evt_count_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      skid_q       <= skid_d;
      cnt_q        <= cnt_d;
      inflight_q   <= inflight_d;
      limit_q      <= limit_d;
      idx_q        <= idx_d;
      evt_data_q   <= evt_data_d;
      evt_valid_q  <= evt_valid_d;
      evt_sof_q    <= evt_sof_d;
      evt_eof_q    <= evt_eof_d;
      evt_ch_q     <= evt_ch_d;
      stopcell_q   <= stopcell_d;
      stopch_q     <= stopch_d;
      flag_a_q     <= flag_a_d;
      flag_b_q     <= flag_b_d;
      hdr_strobe_q <= hdr_strobe_d;
      err_sync_q   <= err_sync_d;
      evt_count_q  <= evt_count_d;
    end
  end

  assign DFIFO_RD_EN = rd_en;
  assign EVT_DATA    = evt_data_q;
  assign EVT_VALID   = evt_valid_q;
  assign EVT_SOF     = evt_sof_q;
  assign EVT_EOF     = evt_eof_q;
  assign EVT_CH      = evt_ch_q;
  assign STOPCELL    = stopcell_q;
  assign STOPCH      = stopch_q;
  assign FLAG_A      = flag_a_q;
  assign FLAG_B      = flag_b_q;
  assign HDR_STROBE  = hdr_strobe_q;
  assign ERR_SYNC    = err_sync_q;
  assign EVT_COUNT   = evt_count_q;
  assign BUSY        = (state_q != HUNT) || evt_valid_q;
endmodule

// File: tb/tb_drs_event_parse.sv
// Directed bench for drs_event_parse: byte FIFO model, output scoreboard, linear test sequence.
module tb_drs_event_parse;
  logic        CLK = 1'b0;
  logic        RST;
  logic [12:0] READDEPTH;
  logic [7:0]  DFIFO_DOUT;
  logic        DFIFO_EMPTY, DFIFO_VALID, DFIFO_RD_EN;
  logic [15:0] EVT_DATA;
  logic        EVT_VALID, EVT_READY, EVT_SOF, EVT_EOF, EVT_CH;
  logic [9:0]  STOPCELL;
  logic [1:0]  STOPCH;
  logic        FLAG_A, FLAG_B, HDR_STROBE, ERR_SYNC, BUSY;
  logic [15:0] EVT_COUNT;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  src_q[$];
  logic [18:0] exp_q[$];
  int          n_xfer = 0, n_hdr = 0, n_err = 0, cyc = 0, first_cyc = -1, last_cyc = 0;
  int          exp_count = 0;
  bit          pend = 0, rand_ready = 0, prev_stall = 0;
  logic        ready_fixed = 1'b1;
  logic [18:0] prev_word, got, want;

  drs_event_parse dut (
    .CLK(CLK), .RST(RST), .READDEPTH(READDEPTH), .DFIFO_DOUT(DFIFO_DOUT),
    .DFIFO_EMPTY(DFIFO_EMPTY), .DFIFO_VALID(DFIFO_VALID), .DFIFO_RD_EN(DFIFO_RD_EN),
    .EVT_DATA(EVT_DATA), .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_SOF(EVT_SOF),
    .EVT_EOF(EVT_EOF), .EVT_CH(EVT_CH), .STOPCELL(STOPCELL), .STOPCH(STOPCH),
    .FLAG_A(FLAG_A), .FLAG_B(FLAG_B), .HDR_STROBE(HDR_STROBE), .ERR_SYNC(ERR_SYNC),
    .EVT_COUNT(EVT_COUNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO with one-cycle read latency; all inputs change at negedge
  initial begin
    DFIFO_VALID = 1'b0; DFIFO_DOUT = 8'h00; DFIFO_EMPTY = 1'b1;
    forever begin
      @(negedge CLK);
      if (pend && src_q.size() > 0) begin
        DFIFO_DOUT  = src_q.pop_front();
        DFIFO_VALID = 1'b1;
      end else begin
        DFIFO_VALID = 1'b0;
      end
      pend = 0;
      DFIFO_EMPTY = (src_q.size() == 0);
      #1;
      if (DFIFO_RD_EN) begin
        check("rd_en_while_empty", DFIFO_EMPTY, 0);
        pend = 1;
      end
    end
  end

  initial begin
    EVT_READY = 1'b0;
    forever begin
      @(negedge CLK);
      EVT_READY = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Output monitor and scoreboard
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      cyc++;
      if (HDR_STROBE) n_hdr++;
      if (ERR_SYNC) n_err++;
      got = {EVT_SOF, EVT_EOF, EVT_CH, EVT_DATA};
      if (prev_stall) begin
        check("hold_valid", EVT_VALID, 1);
        check("hold_word", got, prev_word);
      end
      prev_stall = !RST && EVT_VALID && !EVT_READY;
      prev_word  = got;
      if (!RST && EVT_VALID && EVT_READY) begin
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          check("word", got, want);
        end
        n_xfer++;
        last_cyc = cyc;
        if (first_cyc < 0) first_cyc = cyc;
      end
    end
  end

  task automatic push_word(input logic [15:0] w);
    src_q.push_back(w[15:8]);
    src_q.push_back(w[7:0]);
  endtask

  task automatic push_frame(input logic fb, input logic fa, input logic [1:0] sch,
                            input logic [9:0] scell, input int depth, input logic [11:0] base,
                            input int bad_idx, input logic [15:0] bad_word);
    logic [15:0] w;
    bit live, is_bad;
    w = {12'hF00, 2'b00, fb, fa};
    push_word(w);
    exp_q.push_back({1'b1, 1'b0, 1'b0, w});
    w = {4'h0, sch, scell};
    push_word(w);
    exp_q.push_back({1'b0, depth == 0, 1'b0, w});
    if (depth == 0) exp_count++;
    live = 1;
    for (int i = 0; i < 2 * depth; i++) begin
      w = (i == bad_idx) ? bad_word : {4'h0, base + 12'(i)};
      push_word(w);
      if (live) begin
        is_bad = 0;
`ifdef DRS_PARSE_SAMPCHK_EN
        is_bad = w[15:12] != 4'h0;
`endif
        if (is_bad) begin
          exp_q.push_back({1'b0, 1'b1, i >= depth, w});
          live = 0;
        end else begin
          exp_q.push_back({1'b0, i == 2 * depth - 1, i >= depth, w});
          if (i == 2 * depth - 1) exp_count++;
        end
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || EVT_VALID) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_drain_left"}, exp_q.size(), 0);
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    int n0, n;
    RST = 1'b1; READDEPTH = 13'd0;
    repeat (3) @(negedge CLK);
    check("rst_rd_en", DFIFO_RD_EN, 0);
    check("rst_valid", EVT_VALID, 0);
    check("rst_data", EVT_DATA, 0);
    check("rst_busy", BUSY, 0);
    check("rst_count", EVT_COUNT, 0);
    check("rst_stopcell", STOPCELL, 0);
    check("rst_hdr_strobe", HDR_STROBE, 0);
    check("rst_err_sync", ERR_SYNC, 0);
    RST = 1'b0;

    // Basic frame, depth 4
    READDEPTH = 13'd4;
    first_cyc = -1;
    push_frame(1'b0, 1'b1, 2'd2, 10'h23A, 4, 12'h123, -1, 16'h0);
    drain("f1", 200);
    check("f1_stopcell", STOPCELL, 10'h23A);
    check("f1_stopch", STOPCH, 2);
    check("f1_flag_a", FLAG_A, 1);
    check("f1_flag_b", FLAG_B, 0);
    check("f1_count", EVT_COUNT, exp_count);
    check("f1_hdr_pulses", n_hdr, 1);
    check("f1_busy_idle", BUSY, 0);
    check("f1_span_ok", (last_cyc - first_cyc) <= 20, 1);

    // Leading garbage: 55 F0 then a real header
    src_q.push_back(8'h55);
    src_q.push_back(8'hF0);
    push_frame(1'b0, 1'b1, 2'd2, 10'h23A, 4, 12'h123, -1, 16'h0);
    drain("f2", 200);
    check("f2_count", EVT_COUNT, exp_count);
    check("f2_hdr_pulses", n_hdr, 2);

    // Zero depth: stop word ends the frame
    READDEPTH = 13'd0;
    push_frame(1'b1, 1'b0, 2'd1, 10'h005, 0, 12'h000, -1, 16'h0);
    drain("f3", 100);
    check("f3_count", EVT_COUNT, exp_count);
    check("f3_hdr_pulses", n_hdr, 3);
    check("f3_flag_b", FLAG_B, 1);
    check("f3_flag_a", FLAG_A, 0);
    check("f3_stopch", STOPCH, 1);
    check("f3_stopcell", STOPCELL, 10'h005);

    // Backpressure with a mid-frame READDEPTH change
    READDEPTH = 13'd6;
    ready_fixed = 1'b0;
    push_frame(1'b1, 1'b1, 2'd3, 10'h3FF, 6, 12'h400, -1, 16'h0);
    repeat (30) @(negedge CLK);
    READDEPTH = 13'd2;
    check("bp_rd_en_off", DFIFO_RD_EN, 0);
    check("bp_valid", EVT_VALID, 1);
    check("bp_data", EVT_DATA, 16'hF003);
    check("bp_busy", BUSY, 1);
    check("bp_fifo_left", src_q.size(), 22);
    rand_ready = 1;
    drain("f4", 400);
    check("f4_count", EVT_COUNT, exp_count);
    check("f4_stopcell", STOPCELL, 10'h3FF);

    // Long frame with random backpressure
    READDEPTH = 13'd1024;
    n0 = n_xfer;
    push_frame(1'b0, 1'b0, 2'd0, 10'h000, 1024, 12'h000, -1, 16'h0);
    drain("f5", 20000);
    check("f5_words", n_xfer - n0, 2050);
    check("f5_count", EVT_COUNT, exp_count);

    // Out-of-range sample in the third position, then a clean frame
    rand_ready = 0;
    ready_fixed = 1'b1;
    READDEPTH = 13'd4;
    push_frame(1'b0, 1'b1, 2'd0, 10'h010, 4, 12'h200, 2, 16'h8123);
    push_frame(1'b1, 1'b0, 2'd1, 10'h020, 4, 12'h300, -1, 16'h0);
    drain("f6", 300);
    check("f6_count", EVT_COUNT, exp_count);
    check("f6_stopcell", STOPCELL, 10'h020);
`ifdef DRS_PARSE_SAMPCHK_EN
    check("f6_err_pulses", n_err, 1);
`else
    check("f6_err_pulses", n_err, 0);
`endif

    // Reset in the middle of a frame
    n0 = n_xfer;
    push_frame(1'b1, 1'b1, 2'd2, 10'h155, 4, 12'h111, -1, 16'h0);
    n = 0;
    while (n_xfer < n0 + 5 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("f7_reached_s3", n_xfer >= n0 + 5, 1);
    RST = 1'b1;
    src_q.delete();
    exp_q.delete();
    @(negedge CLK);
    check("f7_rst_valid", EVT_VALID, 0);
    check("f7_rst_data", EVT_DATA, 0);
    check("f7_rst_count", EVT_COUNT, 0);
    check("f7_rst_stopcell", STOPCELL, 0);
    check("f7_rst_flag_a", FLAG_A, 0);
    check("f7_rst_busy", BUSY, 0);
    RST = 1'b0;
    exp_count = 0;
    push_frame(1'b0, 1'b1, 2'd1, 10'h0AB, 4, 12'h050, -1, 16'h0);
    drain("f7", 200);
    check("f7_count", EVT_COUNT, 1);
    check("f7_stopcell", STOPCELL, 10'h0AB);
    check("f7_flag_a", FLAG_A, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
